ep_exp_scheduler: RTL

//   Shares one combinational e^p polynomial unit (l_p = (359p^2+970p+1000)/1000, unsigned) among
//   NUM_REQ requesters (softmax lanes). Round-robin arbitration, registered operand issue,

---
 rtl/ep_exp_scheduler_if.sv | 30 +++
 rtl/ep_exp_scheduler.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ep_exp_scheduler_if.sv
// Handshake bundle between the softmax lanes, the shared e^p unit and the scheduler.
// slave: scheduler side; master: lanes / unit / response consumer side.
interface ep_exp_scheduler_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned BITWIDTH = 16
);
  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*BITWIDTH-1:0] req_p;
  logic [NUM_REQ-1:0]          req_ready;
  logic [BITWIDTH-1:0]         ep_p;
  logic [BITWIDTH-1:0]         ep_l_p;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [IdW-1:0]              rsp_id;
  logic [BITWIDTH-1:0]         rsp_l_p;
  logic                        rsp_sat;
  logic                        busy;

  modport slave (
    input  req_valid, req_p, ep_l_p, rsp_ready,
    output req_ready, ep_p, rsp_valid, rsp_id, rsp_l_p, rsp_sat, busy
  );

  modport master (
    output req_valid, req_p, ep_l_p, rsp_ready,
    input  req_ready, ep_p, rsp_valid, rsp_id, rsp_l_p, rsp_sat, busy
  );
endinterface

// File: rtl/ep_exp_scheduler.sv
// Round-robin scheduler sharing one combinational e^p polynomial unit among NUM_REQ lanes.
// Grant in IDLE, one CALC cycle while the unit evaluates the registered operand, then the
// captured result is held in RESP until accepted.
// Optional feature: define EP_SAT_EN to clamp operands above P_MAX and flag them on rsp_sat.
module ep_exp_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned BITWIDTH = 16,
  parameter int unsigned P_MAX    = 12
) (
  input logic               clk,
  input logic               rst,
  ep_exp_scheduler_if.slave bus
);
  localparam int unsigned IdW = $clog2(NUM_REQ);
`ifdef EP_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif
  localparam logic [BITWIDTH-1:0] PMaxOp = BITWIDTH'(P_MAX);

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  state_e              state_q;
  logic [IdW-1:0]      rr_ptr_q;
  logic [IdW-1:0]      id_q;
  logic                sat_q;
  logic [BITWIDTH-1:0] ep_p_q;
  logic                rsp_valid_q;
  logic [IdW-1:0]      rsp_id_q;
  logic [BITWIDTH-1:0] rsp_l_p_q;
  logic                rsp_sat_q;

  logic [BITWIDTH-1:0] lane_p [NUM_REQ];
  logic                grant_found;
  logic [IdW-1:0]      grant_idx;
  logic [IdW-1:0]      rr_ptr_next;
  logic [BITWIDTH-1:0] grant_p;
  logic [BITWIDTH-1:0] issue_p;
  logic                issue_sat;

  // Modular add for lane indices; NUM_REQ need not be a power of two.
  function automatic logic [IdW-1:0] wrap_add(input logic [IdW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IdW'(s);
  endfunction

  // Unpack the flat operand bus into per-lane operands.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_p[i] = bus.req_p[i*BITWIDTH +: BITWIDTH];
    end
  end

  // Round-robin search: first valid lane at or after rr_ptr_q, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  // Operand selection with optional clamp so the unit never overflows BITWIDTH.
  always_comb begin
    grant_p     = lane_p[grant_idx];
    issue_sat   = SatEn && (grant_p > PMaxOp);
    issue_p     = issue_sat ? PMaxOp : grant_p;
    rr_ptr_next = wrap_add(grant_idx, 1);
  end

  // One-hot accept, only while idle.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == StIdle && grant_found) bus.req_ready[grant_idx] = 1'b1;
  end

  // Control FSM with registered operand issue and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      sat_q       <= 1'b0;
      ep_p_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_l_p_q   <= '0;
      rsp_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_found) begin
            ep_p_q   <= issue_p;
            id_q     <= grant_idx;
            sat_q    <= issue_sat;
            rr_ptr_q <= rr_ptr_next;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          rsp_l_p_q   <= bus.ep_l_p;
          rsp_id_q    <= id_q;
          rsp_sat_q   <= sat_q;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ep_p      = ep_p_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_l_p   = rsp_l_p_q;
  assign bus.rsp_sat   = rsp_sat_q;
  assign bus.busy      = (state_q != StIdle);
endmodule
